// File: rtl/solve_seq_pkg.sv
// Shared state type and parameter defaults for the solve sequencer.
package solve_seq_pkg;

    localparam int unsigned LIT_W_DEFAULT      = 32;
    localparam int unsigned CYC_W_DEFAULT      = 40;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        SOLVE,
        REPORT
    } seq_state_e;

    function automatic logic accepts_literals(input seq_state_e s);
        return (s == IDLE) || (s == LOAD);
    endfunction

endpackage

// File: rtl/solve_sequencer_lit_fifo.sv
// Synchronous literal buffer; occupancy tracked by a count one bit wider than the pointers.
module lit_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full buffer still takes a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/solve_sequencer.sv
// Buffers a host literal stream into a SAT solver, launches the solve and holds its result.
module solve_sequencer
    import solve_seq_pkg::*;
#(
    parameter int unsigned LIT_W      = LIT_W_DEFAULT,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int unsigned CYC_W      = CYC_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    lit_valid,
    input  logic signed [LIT_W-1:0] lit_data,
    input  logic                    lit_end,
    output logic                    lit_ready,
    input  logic                    go,
    input  logic [CYC_W-1:0]        max_cycles,
    output logic                    load_valid,
    output logic signed [LIT_W-1:0] load_literal,
    output logic                    load_clause_end,
    input  logic                    load_ready,
    output logic                    start_solve,
    input  logic                    done,
    input  logic                    sat,
    input  logic                    unsat,
    output logic                    result_valid,
    output logic                    result_sat,
    output logic                    result_unsat,
    output logic                    result_timeout,
    input  logic                    result_ack,
    output logic [CYC_W-1:0]        cycle_count,
    output logic [31:0]             clause_count,
    output logic [31:0]             lit_count,
    output logic                    err_zero_lit,
    output logic                    busy
);

    seq_state_e       state_q;
    logic             rdy_en_q, pending_q;
    logic [CYC_W-1:0] cyc_q;
    logic [31:0]      lit_cnt_q, cls_cnt_q;
    logic             err_q, res_valid_q, res_sat_q, res_unsat_q, res_to_q;

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [LIT_W:0]   fifo_head;
    logic             in_load, beat_acc, beat_zero, start_ok, timed_out;

    assign in_load   = accepts_literals(state_q);
    // rdy_en_q keeps lit_ready low through reset and releases it on the first edge after.
    assign lit_ready = rdy_en_q && in_load && !fifo_full;
    assign beat_acc  = lit_valid && lit_ready;
    assign beat_zero = (lit_data == '0);
    assign fifo_push = beat_acc && !beat_zero;

    assign load_valid      = in_load && !fifo_empty;
    assign fifo_pop        = load_valid && load_ready;
    assign load_literal    = fifo_empty ? '0 : fifo_head[LIT_W-1:0];
    assign load_clause_end = !fifo_empty && fifo_head[LIT_W];

    assign start_ok  = pending_q && fifo_empty && !fifo_push;
    assign timed_out = (cyc_q == max_cycles);

    assign start_solve    = (state_q == START);
    assign busy           = (state_q != IDLE);
    assign result_valid   = res_valid_q;
    assign result_sat     = res_sat_q;
    assign result_unsat   = res_unsat_q;
    assign result_timeout = res_to_q;
    assign cycle_count    = cyc_q;
    assign lit_count      = lit_cnt_q;
    assign clause_count   = cls_cnt_q;
    assign err_zero_lit   = err_q;

    lit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LIT_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i ({lit_end, lit_data}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rdy_en_q    <= 1'b0;
            pending_q   <= 1'b0;
            cyc_q       <= '0;
            lit_cnt_q   <= '0;
            cls_cnt_q   <= '0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_sat_q   <= 1'b0;
            res_unsat_q <= 1'b0;
            res_to_q    <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (fifo_pop) begin
                lit_cnt_q <= lit_cnt_q + 32'd1;
                if (fifo_head[LIT_W]) begin
                    cls_cnt_q <= cls_cnt_q + 32'd1;
                end
            end
            if (beat_acc && beat_zero) begin
                err_q <= 1'b1;
            end
            if (in_load && go) begin
                pending_q <= 1'b1;
            end

            unique case (state_q)
                IDLE, LOAD: begin
                    if (start_ok) begin
                        state_q   <= START;
                        pending_q <= 1'b0;
                        cyc_q     <= '0;
                    end else if ((state_q == IDLE) && fifo_push) begin
                        state_q <= LOAD;
                    end
                end
                START: begin
                    state_q <= SOLVE;
                end
                SOLVE: begin
                    // The counter freezes on the exit cycle so it reports the cycle the solve ended on.
                    if (done) begin
                        state_q     <= REPORT;
                        res_valid_q <= 1'b1;
                        res_sat_q   <= sat;
                        res_unsat_q <= unsat;
                        res_to_q    <= 1'b0;
                    end else if (timed_out) begin
                        state_q     <= REPORT;
                        res_valid_q <= 1'b1;
                        res_sat_q   <= 1'b0;
                        res_unsat_q <= 1'b0;
                        res_to_q    <= 1'b1;
                    end else if (cyc_q != '1) begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                REPORT: begin
                    if (result_ack) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        res_sat_q   <= 1'b0;
                        res_unsat_q <= 1'b0;
                        res_to_q    <= 1'b0;
                        lit_cnt_q   <= '0;
                        cls_cnt_q   <= '0;
                        err_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_solve_sequencer.sv
// Self-checking bench for solve_sequencer: directed scenarios plus randomized jobs against a queue model.
module tb_solve_sequencer;

    localparam int unsigned LW    = 32;
    localparam int unsigned CW    = 40;
    localparam int          NEVER = 1000000;

    typedef struct {
        logic signed [31:0] lit;
        logic               ce;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 lit_valid, lit_end, lit_ready;
    logic signed [LW-1:0] lit_data;
    logic                 go;
    logic [CW-1:0]        max_cycles;
    logic                 load_valid, load_clause_end, load_ready;
    logic signed [LW-1:0] load_literal;
    logic                 start_solve, done, sat, unsat;
    logic                 result_valid, result_sat, result_unsat, result_timeout, result_ack;
    logic [CW-1:0]        cycle_count;
    logic [31:0]          clause_count, lit_count;
    logic                 err_zero_lit, busy;

    solve_sequencer #(
        .LIT_W      (LW),
        .FIFO_DEPTH (16),
        .CYC_W      (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .lit_valid       (lit_valid),
        .lit_data        (lit_data),
        .lit_end         (lit_end),
        .lit_ready       (lit_ready),
        .go              (go),
        .max_cycles      (max_cycles),
        .load_valid      (load_valid),
        .load_literal    (load_literal),
        .load_clause_end (load_clause_end),
        .load_ready      (load_ready),
        .start_solve     (start_solve),
        .done            (done),
        .sat             (sat),
        .unsat           (unsat),
        .result_valid    (result_valid),
        .result_sat      (result_sat),
        .result_unsat    (result_unsat),
        .result_timeout  (result_timeout),
        .result_ack      (result_ack),
        .cycle_count     (cycle_count),
        .clause_count    (clause_count),
        .lit_count       (lit_count),
        .err_zero_lit    (err_zero_lit),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_pass = 0;
    int    tmo = 0;
    int    start_cnt = 0;
    bit    rnd_lr = 1'b0;
    beat_t got_q[$];
    beat_t exp_q[$];

    // Load-port beats and start pulses observed mid-cycle, away from the clock edge.
    always @(negedge clk) begin
        if (load_valid && load_ready) begin
            got_q.push_back(beat_t'{lit: load_literal, ce: load_clause_end});
        end
        if (start_solve) begin
            start_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic signed [31:0] d, input logic e);
        bit ok;
        ok = 1'b0;
        lit_valid = 1'b1;
        lit_data  = d;
        lit_end   = e;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = lit_ready;
            tick();
            if (rnd_lr) load_ready = 1'($urandom_range(0, 1));
        end
        lit_valid = 1'b0;
        lit_data  = '0;
        lit_end   = 1'b0;
        if (!ok) tmo++;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = !load_valid;
        end
        if (!ok) tmo++;
        tick();
    endtask

    // Issues go, then asserts done on the SOLVE cycle whose cycle_count equals dly.
    task automatic run_solve(input int dly, input bit s, input bit u, input int m);
        bit found;
        max_cycles = CW'(m);
        go = 1'b1;
        tick();
        go = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            found = start_solve;
        end
        if (!found) tmo++;
        tick();
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            if (result_valid) begin
                found = 1'b1;
            end else begin
                if (cycle_count == CW'(dly)) begin
                    done  = 1'b1;
                    sat   = s;
                    unsat = u;
                end
                tick();
                done  = 1'b0;
                sat   = 1'b0;
                unsat = 1'b0;
            end
        end
        if (!found) tmo++;
    endtask

    task automatic ack_result();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({lit_ready, load_valid, load_clause_end, start_solve, result_valid, result_sat,
             result_unsat, result_timeout, err_zero_lit, busy} !== '0)
            $display("FAIL reset_flags: got %b expected all zero", {lit_ready, load_valid,
                     load_clause_end, start_solve, result_valid, result_sat, result_unsat,
                     result_timeout, err_zero_lit, busy});
        else n_pass++;
        n_chk++;
        if (cycle_count !== '0 || lit_count !== '0 || clause_count !== '0 || load_literal !== '0)
            $display("FAIL reset_counters: got cyc=%0d lits=%0d cls=%0d lit=%0d expected 0",
                     cycle_count, lit_count, clause_count, load_literal);
        else n_pass++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (lit_ready !== 1'b0) $display("FAIL reset_ready_before_edge: got %b expected 0", lit_ready);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (lit_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_ready_after_edge: got ready=%b busy=%b expected 1/0", lit_ready, busy);
        else n_pass++;
        tick();
    endtask

    task automatic test_basic();
        got_q.delete();
        exp_q.delete();
        start_cnt = 0;
        load_ready = 1'b1;
        exp_q.push_back(beat_t'{lit: 1, ce: 1'b0});
        exp_q.push_back(beat_t'{lit: -2, ce: 1'b1});
        exp_q.push_back(beat_t'{lit: 3, ce: 1'b1});
        foreach (exp_q[i]) send_beat(exp_q[i].lit, exp_q[i].ce);
        wait_drain();
        n_chk++;
        if (got_q.size() !== 3) $display("FAIL basic_beat_count: got %0d expected 3", got_q.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_chk++;
            if (got_q[i].lit !== exp_q[i].lit || got_q[i].ce !== exp_q[i].ce)
                $display("FAIL basic_beat%0d: got %0d/%b expected %0d/%b", i, got_q[i].lit,
                         got_q[i].ce, exp_q[i].lit, exp_q[i].ce);
            else n_pass++;
        end
        run_solve(3, 1'b0, 1'b1, 50);
        n_chk++;
        if (start_cnt !== 1) $display("FAIL basic_start_pulses: got %0d expected 1", start_cnt);
        else n_pass++;
        n_chk++;
        if (lit_count !== 32'd3 || clause_count !== 32'd2)
            $display("FAIL basic_counts: got lits=%0d cls=%0d expected 3/2", lit_count, clause_count);
        else n_pass++;
        n_chk++;
        if ({result_valid, result_sat, result_unsat, result_timeout} !== 4'b1010 || cycle_count !== CW'(3))
            $display("FAIL basic_result: got %b cyc=%0d expected 1010 cyc=3",
                     {result_valid, result_sat, result_unsat, result_timeout}, cycle_count);
        else n_pass++;
        ack_result();
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || lit_count !== '0 || clause_count !== '0 || result_valid !== 1'b0)
            $display("FAIL basic_after_ack: got busy=%b lits=%0d cls=%0d valid=%b expected 0",
                     busy, lit_count, clause_count, result_valid);
        else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        got_q.delete();
        exp_q.delete();
        load_ready = 1'b0;
        for (int i = 1; i <= 17; i++) exp_q.push_back(beat_t'{lit: i * 7 - 40, ce: 1'((i % 4) == 0)});
        for (int i = 0; i < 16; i++) send_beat(exp_q[i].lit, exp_q[i].ce);
        @(negedge clk);
        n_chk++;
        if (lit_ready !== 1'b0 || load_valid !== 1'b1 || got_q.size() !== 0)
            $display("FAIL bp_full: got ready=%b valid=%b popped=%0d expected 0/1/0",
                     lit_ready, load_valid, got_q.size());
        else n_pass++;
        tick();
        load_ready = 1'b1;
        send_beat(exp_q[16].lit, exp_q[16].ce);
        wait_drain();
        n_chk++;
        if (got_q.size() !== 17) $display("FAIL bp_beat_count: got %0d expected 17", got_q.size());
        else n_pass++;
        for (int i = 0; i < 17 && i < got_q.size(); i++) begin
            n_chk++;
            if (got_q[i].lit !== exp_q[i].lit || got_q[i].ce !== exp_q[i].ce)
                $display("FAIL bp_beat%0d: got %0d/%b expected %0d/%b", i, got_q[i].lit,
                         got_q[i].ce, exp_q[i].lit, exp_q[i].ce);
            else n_pass++;
        end
        n_chk++;
        if (lit_count !== 32'd17 || clause_count !== 32'd4)
            $display("FAIL bp_counts: got lits=%0d cls=%0d expected 17/4", lit_count, clause_count);
        else n_pass++;
        run_solve(2, 1'b1, 1'b0, 50);
        ack_result();
    endtask

    task automatic test_timeout();
        load_ready = 1'b1;
        send_beat(4, 1'b1);
        wait_drain();
        run_solve(NEVER, 1'b0, 1'b0, 100);
        n_chk++;
        if ({result_valid, result_sat, result_unsat, result_timeout} !== 4'b1001 || cycle_count !== CW'(100))
            $display("FAIL timeout_result: got %b cyc=%0d expected 1001 cyc=100",
                     {result_valid, result_sat, result_unsat, result_timeout}, cycle_count);
        else n_pass++;
        repeat (5) tick();
        @(negedge clk);
        n_chk++;
        if ({result_valid, result_timeout, busy} !== 3'b111 || cycle_count !== CW'(100))
            $display("FAIL timeout_hold: got valid/to/busy=%b cyc=%0d expected 111 cyc=100",
                     {result_valid, result_timeout, busy}, cycle_count);
        else n_pass++;
        tick();
        ack_result();
        @(negedge clk);
        n_chk++;
        if (result_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL timeout_ack: got valid=%b busy=%b expected 0/0", result_valid, busy);
        else n_pass++;
        tick();
        run_solve(NEVER, 1'b0, 1'b0, 0);
        n_chk++;
        if ({result_valid, result_sat, result_unsat, result_timeout} !== 4'b1001 || cycle_count !== '0)
            $display("FAIL zero_budget_timeout: got %b cyc=%0d expected 1001 cyc=0",
                     {result_valid, result_sat, result_unsat, result_timeout}, cycle_count);
        else n_pass++;
        ack_result();
        run_solve(0, 1'b1, 1'b0, 0);
        n_chk++;
        if ({result_valid, result_sat, result_unsat, result_timeout} !== 4'b1100)
            $display("FAIL zero_budget_done: got %b expected 1100",
                     {result_valid, result_sat, result_unsat, result_timeout});
        else n_pass++;
        ack_result();
    endtask

    task automatic test_done_tie();
        load_ready = 1'b1;
        send_beat(-5, 1'b1);
        wait_drain();
        run_solve(5, 1'b1, 1'b0, 5);
        n_chk++;
        if ({result_valid, result_sat, result_unsat, result_timeout} !== 4'b1100 || cycle_count !== CW'(5))
            $display("FAIL tie_result: got %b cyc=%0d expected 1100 cyc=5",
                     {result_valid, result_sat, result_unsat, result_timeout}, cycle_count);
        else n_pass++;
        ack_result();
    endtask

    task automatic test_zero_lit();
        got_q.delete();
        load_ready = 1'b1;
        send_beat(7, 1'b0);
        send_beat(0, 1'b0);
        send_beat(-8, 1'b1);
        wait_drain();
        n_chk++;
        if (got_q.size() !== 2 || (got_q.size() == 2 && (got_q[0].lit !== 7 || got_q[0].ce !== 1'b0 ||
            got_q[1].lit !== -8 || got_q[1].ce !== 1'b1)))
            $display("FAIL zero_beats: got %0d beats expected 7/0 then -8/1", got_q.size());
        else n_pass++;
        n_chk++;
        if (err_zero_lit !== 1'b1 || lit_count !== 32'd2 || clause_count !== 32'd1)
            $display("FAIL zero_flags: got err=%b lits=%0d cls=%0d expected 1/2/1",
                     err_zero_lit, lit_count, clause_count);
        else n_pass++;
        run_solve(1, 1'b1, 1'b0, 20);
        ack_result();
        @(negedge clk);
        n_chk++;
        if (err_zero_lit !== 1'b0) $display("FAIL zero_err_clear: got %b expected 0", err_zero_lit);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        bit found;
        load_ready = 1'b0;
        send_beat(9, 1'b0);
        send_beat(10, 1'b1);
        rst = 1'b1;
        #1;
        n_chk++;
        if (load_valid !== 1'b0 || busy !== 1'b0 || lit_ready !== 1'b0)
            $display("FAIL rst_load: got valid=%b busy=%b ready=%b expected 0", load_valid, busy, lit_ready);
        else n_pass++;
        tick();
        rst = 1'b0;
        load_ready = 1'b1;
        send_beat(11, 1'b1);
        wait_drain();
        go = 1'b1;
        tick();
        go = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            found = start_solve;
        end
        if (!found) tmo++;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        n_chk++;
        if (busy !== 1'b0 || start_solve !== 1'b0 || result_valid !== 1'b0 || cycle_count !== '0)
            $display("FAIL rst_solve: got busy=%b start=%b valid=%b cyc=%0d expected 0",
                     busy, start_solve, result_valid, cycle_count);
        else n_pass++;
        tick();
        rst = 1'b0;
        got_q.delete();
        send_beat(12, 1'b0);
        send_beat(13, 1'b1);
        wait_drain();
        n_chk++;
        if (got_q.size() !== 2 || (got_q.size() == 2 && (got_q[0].lit !== 12 || got_q[1].lit !== 13)))
            $display("FAIL rst_fresh_beats: got %0d beats expected 12 then 13", got_q.size());
        else n_pass++;
        run_solve(4, 1'b0, 1'b1, 30);
        n_chk++;
        if ({result_valid, result_unsat, result_timeout} !== 3'b110 || lit_count !== 32'd2)
            $display("FAIL rst_fresh_result: got valid/unsat/to=%b lits=%0d expected 110/2",
                     {result_valid, result_unsat, result_timeout}, lit_count);
        else n_pass++;
        ack_result();
    endtask

    task automatic test_random();
        for (int job = 0; job < 6; job++) begin
            int  nl, nc, ncl, len, v, dly, m;
            bit  zero_seen, s;
            logic [3:0] exp_res;
            got_q.delete();
            exp_q.delete();
            nl = 0;
            nc = 0;
            zero_seen = 1'b0;
            rnd_lr = 1'b1;
            ncl = int'($urandom_range(1, 4));
            for (int c = 0; c < ncl; c++) begin
                len = int'($urandom_range(1, 3));
                for (int k = 0; k < len; k++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        send_beat(0, 1'($urandom_range(0, 1)));
                        zero_seen = 1'b1;
                    end
                    v = int'($urandom_range(1, 5000));
                    if ($urandom_range(0, 1) == 1) v = -v;
                    exp_q.push_back(beat_t'{lit: v, ce: 1'(k == len - 1)});
                    send_beat(v, 1'(k == len - 1));
                    nl++;
                    if (k == len - 1) nc++;
                end
            end
            rnd_lr = 1'b0;
            load_ready = 1'b1;
            wait_drain();
            n_chk++;
            if (got_q.size() !== exp_q.size())
                $display("FAIL rand%0d_beat_count: got %0d expected %0d", job, got_q.size(), exp_q.size());
            else n_pass++;
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_chk++;
                if (got_q[i].lit !== exp_q[i].lit || got_q[i].ce !== exp_q[i].ce)
                    $display("FAIL rand%0d_beat%0d: got %0d/%b expected %0d/%b", job, i,
                             got_q[i].lit, got_q[i].ce, exp_q[i].lit, exp_q[i].ce);
                else n_pass++;
            end
            n_chk++;
            if (lit_count !== 32'(nl) || clause_count !== 32'(nc) || err_zero_lit !== zero_seen)
                $display("FAIL rand%0d_counts: got lits=%0d cls=%0d err=%b expected %0d/%0d/%b",
                         job, lit_count, clause_count, err_zero_lit, nl, nc, zero_seen);
            else n_pass++;
            dly = int'($urandom_range(0, 25));
            m   = int'($urandom_range(0, 25));
            s   = 1'($urandom_range(0, 1));
            run_solve(dly, s, !s, m);
            exp_res = (dly <= m) ? {1'b1, s, !s, 1'b0} : 4'b1001;
            n_chk++;
            if ({result_valid, result_sat, result_unsat, result_timeout} !== exp_res ||
                cycle_count !== CW'((dly <= m) ? dly : m))
                $display("FAIL rand%0d_result: got %b cyc=%0d expected %b cyc=%0d", job,
                         {result_valid, result_sat, result_unsat, result_timeout}, cycle_count,
                         exp_res, (dly <= m) ? dly : m);
            else n_pass++;
            ack_result();
        end
    endtask

    initial begin
        rst        = 1'b1;
        lit_valid  = 1'b0;
        lit_data   = '0;
        lit_end    = 1'b0;
        go         = 1'b0;
        max_cycles = '0;
        load_ready = 1'b0;
        done       = 1'b0;
        sat        = 1'b0;
        unsat      = 1'b0;
        result_ack = 1'b0;

        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_done_tie();
        test_zero_lit();
        test_reset_mid();
        test_random();

        n_chk++;
        if (tmo !== 0) $display("FAIL handshake_bounds: got %0d expired waits expected 0", tmo);
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
